// File: rtl/food_placer.sv
// Food placement controller: draws random candidate cells, asks the snake-body
// responder whether each is occupied, and commits the first free one.
module food_placer #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       place_req,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    output logic [5:0] query_x,
    output logic [5:0] query_y,
    output logic       query_valid,
    input  logic       query_occupied,
    output logic [5:0] food_x,
    output logic [5:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    // state  | meaning
    // IDLE   | waiting for place_req
    // SAMPLE | latch reduced random candidate into query_x/query_y
    // QUERY  | query_valid strobe to the occupancy responder
    // WAIT   | responder answer sampled; commit, retry or give up
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        QUERY  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [6:0] GW  = 7'(GRID_W);
    localparam logic [6:0] GH  = 7'(GRID_H);
    localparam logic [7:0] MAX = 8'(MAX_TRIES);

    state_t     state, state_nxt;
    logic [7:0] try_cnt;
    logic [7:0] try_nxt;
    logic [6:0] raw_x, raw_y;
    logic [6:0] diff_x, diff_y;
    logic [5:0] red_x, red_y;
    logic       unused_rand;

    assign unused_rand = ^{rand_x[9:6], rand_y[9:6]};

    // GRID >= 33 means one subtraction always lands a 6-bit value in range
    assign raw_x  = {1'b0, rand_x[5:0]};
    assign raw_y  = {1'b0, rand_y[5:0]};
    assign diff_x = raw_x - GW;
    assign diff_y = raw_y - GH;
    assign red_x  = (raw_x >= GW) ? diff_x[5:0] : rand_x[5:0];
    assign red_y  = (raw_y >= GH) ? diff_y[5:0] : rand_y[5:0];

    assign try_nxt     = try_cnt + 8'd1;
    assign busy        = (state != IDLE);
    assign query_valid = (state == QUERY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (place_req) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = QUERY;
            QUERY:   state_nxt = WAIT;
            WAIT: begin
                if (!query_occupied || try_nxt == MAX) state_nxt = IDLE;
                else                                   state_nxt = SAMPLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            try_cnt    <= 8'd0;
            query_x    <= 6'd0;
            query_y    <= 6'd0;
            food_x     <= 6'd0;
            food_y     <= 6'd0;
            food_valid <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            fail  <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_req) begin
                        food_valid <= 1'b0;
                        try_cnt    <= 8'd0;
                    end
                end
                SAMPLE: begin
                    query_x <= red_x;
                    query_y <= red_y;
                end
                WAIT: begin
                    try_cnt <= try_nxt;
                    if (!query_occupied) begin
                        food_x     <= query_x;
                        food_y     <= query_y;
                        food_valid <= 1'b1;
                        done       <= 1'b1;
                    end else if (try_nxt == MAX) begin
                        fail <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
